// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: sync pulses, active-video flag, pixel coordinates,
// line/frame strobes and a free-running frame counter, all registered and skew-free.
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int unsigned CW      = 10;
  localparam int unsigned EW      = CW + 1;
  localparam int unsigned FW      = 8;
  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  // Bounds carried one bit wider so an end value of 1024 still compares correctly.
  localparam logic [EW-1:0] H_ACT    = EW'(H_DISPLAY);
  localparam logic [EW-1:0] V_ACT    = EW'(V_DISPLAY);
  localparam logic [EW-1:0] HS_START = EW'(H_DISPLAY + H_FRONT);
  localparam logic [EW-1:0] HS_END   = EW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [EW-1:0] VS_START = EW'(V_DISPLAY + V_FRONT);
  localparam logic [EW-1:0] VS_END   = EW'(V_DISPLAY + V_FRONT + V_SYNC);

  logic          h_last;
  logic          v_last;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic [EW-1:0] h_ext;
  logic [EW-1:0] v_ext;
  logic          disp_nxt;
  logic          hs_act_nxt;
  logic          vs_act_nxt;

  // Next coordinates and the flags decoded from them, so flags land with the counters.
  always_comb begin
    h_last     = (hpos == H_LAST);
    v_last     = (vpos == V_LAST);
    h_nxt      = hpos + CW'(1);
    v_nxt      = vpos;
    if (h_last) begin
      h_nxt = '0;
      v_nxt = v_last ? '0 : vpos + CW'(1);
    end
    h_ext      = {1'b0, h_nxt};
    v_ext      = {1'b0, v_nxt};
    disp_nxt   = (h_ext < H_ACT) && (v_ext < V_ACT);
    hs_act_nxt = (h_ext >= HS_START) && (h_ext < HS_END);
    vs_act_nxt = (v_ext >= VS_START) && (v_ext < VS_END);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos        <= '0;
      vpos        <= '0;
      frame_cnt   <= '0;
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      display_on  <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_tick) begin
      hpos        <= h_nxt;
      vpos        <= v_nxt;
      display_on  <= disp_nxt;
      hsync       <= hs_act_nxt ? H_SYNC_POL : ~H_SYNC_POL;
      vsync       <= vs_act_nxt ? V_SYNC_POL : ~V_SYNC_POL;
      line_start  <= h_last;
      frame_start <= h_last && v_last;
      if (h_last && v_last) begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for line behaviour and mid-line reset,
// small-timing instance for frames, pix_tick gating and frame counter wrap.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, rst_b = 1'b0, tick_a = 1'b0, tick_b = 1'b0;
  logic       hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0] h_a, v_a;
  logic [7:0] fc_a;
  logic       hs_b, vs_b, de_b, ls_b, fs_b;
  logic [9:0] h_b, v_b;
  logic [7:0] fc_b;

  vga_timing_gen dut_a (
    .clk(clk), .reset(rst_a), .pix_tick(tick_a),
    .hsync(hs_a), .vsync(vs_a), .display_on(de_a),
    .hpos(h_a), .vpos(v_a), .line_start(ls_a),
    .frame_start(fs_a), .frame_cnt(fc_a)
  );

  // H: 4 active, 1 front, 2 sync (hpos 5..6, active-high), 1 back = 8
  // V: 3 active, 1 front, 1 sync (vpos 4, active-low), 1 back = 6 -> 48 ticks/frame
  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .reset(rst_b), .pix_tick(tick_b),
    .hsync(hs_b), .vsync(vs_b), .display_on(de_b),
    .hpos(h_b), .vpos(v_b), .line_start(ls_b),
    .frame_start(fs_b), .frame_cnt(fc_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int h, input int v, input bit ls, input bit fs);
    chk({tag, ".hpos"},  32'(h_a),  32'(h));
    chk({tag, ".vpos"},  32'(v_a),  32'(v));
    chk({tag, ".de"},    32'(de_a), 32'(h < 640 && v < 480));
    chk({tag, ".hsync"}, 32'(hs_a), 32'(!(h >= 656 && h < 752)));
    chk({tag, ".vsync"}, 32'(vs_a), 32'(!(v >= 490 && v < 492)));
    chk({tag, ".ls"},    32'(ls_a), 32'(ls));
    chk({tag, ".fs"},    32'(fs_a), 32'(fs));
    chk({tag, ".fc"},    32'(fc_a), 32'(0));
  endtask

  int         mh = 0, mv = 0, clk_idx = 0, fs_seen = 0, fs_clk1 = 0, fs_clk2 = 0;
  logic [7:0] mfc = 8'd0;
  bit         ls_e = 1'b0, fs_e = 1'b0;

  // One clock of dut_b with an independent reference model of the small timing.
  task automatic b_cycle(input bit t);
    logic [7:0] fc_before;
    fc_before = fc_b;
    tick_b = t;
    @(posedge clk); #1;
    ls_e = 1'b0;
    fs_e = 1'b0;
    if (t) begin
      if (mh == 7) begin
        mh   = 0;
        ls_e = 1'b1;
        if (mv == 5) begin
          mv   = 0;
          fs_e = 1'b1;
          mfc  = mfc + 8'd1;
        end else begin
          mv = mv + 1;
        end
      end else begin
        mh = mh + 1;
      end
    end
    chk("b.hpos",  32'(h_b),  32'(mh));
    chk("b.vpos",  32'(v_b),  32'(mv));
    chk("b.de",    32'(de_b), 32'(mh < 4 && mv < 3));
    chk("b.hsync", 32'(hs_b), 32'(mh >= 5 && mh < 7));
    chk("b.vsync", 32'(vs_b), 32'(mv != 4));
    chk("b.ls",    32'(ls_b), 32'(ls_e));
    chk("b.fs",    32'(fs_b), 32'(fs_e));
    chk("b.fc",    32'(fc_b), 32'(mfc));
    if (fs_e) begin
      fs_seen++;
      if (fs_seen == 1) fs_clk1 = clk_idx;
      if (fs_seen == 2) fs_clk2 = clk_idx;
      if (fs_seen == 256) begin
        chk("b.fc_before_wrap", 32'(fc_before), 32'(255));
        chk("b.fc_wrap",        32'(fc_b),      32'(0));
      end
    end
    clk_idx++;
  endtask

  initial begin
    int hs_low;
    hs_low = 0;

    // Asynchronous reset, checked before any clock edge.
    #2 rst_a = 1'b1; rst_b = 1'b1;
    #1;
    chk_a("rst_a", 0, 0, 1'b0, 1'b0);
    chk("rst_b.hsync", 32'(hs_b), 32'(0));
    chk("rst_b.vsync", 32'(vs_b), 32'(1));
    chk("rst_b.de",    32'(de_b), 32'(1));
    chk("rst_b.hpos",  32'(h_b),  32'(0));
    chk("rst_b.fc",    32'(fc_b), 32'(0));

    // Line 0 of the default timing, every pixel.
    @(negedge clk);
    rst_a = 1'b0;
    tick_a = 1'b1;
    for (int i = 1; i < 800; i++) begin
      @(posedge clk); #1;
      chk_a("line0", i, 0, 1'b0, 1'b0);
      if (hs_a == 1'b0) hs_low++;
    end
    chk("hsync_width", 32'(hs_low), 32'(96));
    @(posedge clk); #1;
    chk_a("wrap", 0, 1, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk_a("after_wrap", 1, 1, 1'b0, 1'b0);
    repeat (299) @(posedge clk);
    #1;
    chk_a("pre_rst", 300, 1, 1'b0, 1'b0);

    // Mid-line reset between edges, then resume with no strobes.
    rst_a = 1'b1;
    #1;
    chk_a("mid_rst", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk_a("post_rst", i, 0, 1'b0, 1'b0);
    end
    tick_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_a("hold_a", 3, 0, 1'b0, 1'b0);

    // Small timing: two frames with pix_tick alternating, then steady ticks to 256 frames.
    @(negedge clk);
    rst_b = 1'b0;
    for (int c = 0; c < 192; c++) b_cycle((c % 2) == 0);
    chk("b.frames_toggled", 32'(fs_seen), 32'(2));
    chk("b.frame_len_toggled", 32'(fs_clk2 - fs_clk1), 32'(96));
    for (int c = 0; c < 254 * 48; c++) b_cycle(1'b1);
    chk("b.frames_total", 32'(fs_seen), 32'(256));
    chk("b.fc_end", 32'(fc_b), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-timing generator for the VGA output path: produces hsync, vsync, the active-video flag and the current pixel coordinates.
- Downstream pattern/colour logic consumes these to drive the TinyVGA PMOD pins.
- Default timing is 640x480@60 with a ~25 MHz pixel clock.
- Adds a pixel-clock enable, line/frame start strobes and a free-running frame counter, so animation logic need not clock off vsync.

Parameters:
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of hsync (0 = active-low)
- V_SYNC_POL, 0, asserted level of vsync (0 = active-low)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pix_tick  input  1  pixel clock enable; tie to 1 when clk is the pixel clock
- hsync  output  1  horizontal sync, level per H_SYNC_POL
- vsync  output  1  vertical sync, level per V_SYNC_POL
- display_on  output  1  1 while (hpos,vpos) is inside the active area
- hpos  output  10  current pixel column, 0..H_TOTAL-1
- vpos  output  10  current line, 0..V_TOTAL-1
- line_start  output  1  one-clk strobe: hpos just wrapped to 0
- frame_start  output  1  one-clk strobe: (hpos,vpos) just wrapped to (0,0)
- frame_cnt  output  8  frames completed since reset, wraps at 255->0

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high (port reset); it clears all state immediately, independent of clk.
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Reset values:
  - hpos=0, vpos=0, frame_cnt=0
  - hsync=~H_SYNC_POL, vsync=~V_SYNC_POL
  - display_on=1
  - line_start=0, frame_start=0
- Counter advance: on each rising clk edge with pix_tick=1, hpos increments.
  - hpos==H_TOTAL-1 -> hpos=0 and vpos increments.
  - vpos==V_TOTAL-1 at that same point -> vpos=0 and frame_cnt increments (modulo 256).
  - pix_tick=0 -> every output holds its value, except the strobes, which are 0.
- All outputs are registered, and each one matches the current registered hpos/vpos in the same cycle. Implement by decoding next-state counter values into the flops; zero-cycle skew between coordinates and flags.
- display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY).
- hsync asserted iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC, i.e. 656..751.
- vsync asserted iff V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC, i.e. 490..491. vsync changes in the same cycle hpos wraps to 0.
- Strobes:
  - line_start = 1 exactly for the clk cycle in which hpos became 0 through a wrap.
  - frame_start = 1 exactly for the cycle in which (hpos,vpos) became (0,0) through a wrap; line_start is also 1 in that cycle.
  - Neither strobe fires on reset release: the first tick after release moves hpos to 1.
- Width rule: counters are 10 bits. Parameters must give H_TOTAL and V_TOTAL <= 1024; otherwise elaboration error.
- Reset mid-frame: all outputs return to reset values asynchronously. Counting resumes from (0,0) on the first ticked edge after release. No partial strobe is emitted.

Test Plan:
- Reset, release, pix_tick=1 -> hpos counts 0,1,2...; after 799 ticks hpos=799, vpos=0; next tick hpos=0, vpos=1, line_start=1 for one clk, frame_start=0.
- Sweep one line -> display_on=1 for hpos 0..639 and 0 for 640..799; hsync=0 exactly for hpos 656..751 (96 clks); hsync=1 otherwise.
- Run a full frame -> vsync=0 only on vpos 490..491 (1600 clks); at tick 420000, (hpos,vpos)=(0,0), frame_start=1, line_start=1, frame_cnt=1.
- pix_tick toggling 1,0,1,0 -> counters advance every second clk; strobes are one clk wide; a full frame takes 840000 clks.
- Assert reset at hpos=300, vpos=200 -> outputs go to reset values with no clock edge; release, then 3 ticks -> hpos=3, vpos=0, no strobes seen.
- Run 256 frames -> frame_cnt wraps 255->0 coincident with the 256th frame_start.
